// File: rtl/axi_ic_pkg.sv
`default_nettype none
// ============================================================================
// axi_ic_pkg : shared types and constants for the 4x8 AXI4 interconnect
// Rev 1.0
// ============================================================================
package axi_ic_pkg;

   localparam int NUM_M = 4;
   localparam int NUM_S = 8;

   // Slave select lives in the top address bits
   localparam int ADDR_W      = 32;
   localparam int SLV_SEL_W   = $clog2(NUM_S);
   localparam int SLV_SEL_MSB = ADDR_W - 1;
   localparam int SLV_SEL_LSB = ADDR_W - SLV_SEL_W;

   typedef logic [1:0] m_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2
   } rd_arb_state_e;

endpackage : axi_ic_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, searches from last+1 circularly
// Rev 1.0
// ============================================================================
module rr_pick
   import axi_ic_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] gnt_oh,
   output logic [1:0] gnt_idx,
   output logic       any
);

   m_idx_t w_cand;
   logic   w_found;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_cand  = last;
      // Offset NUM_M wraps back to last itself, so it is searched last
      for (int k = 1; k <= NUM_M; k++) begin
         w_cand = last + m_idx_t'(k);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            gnt_idx = w_cand;
            gnt_oh  = 4'b0001 << w_cand;
         end
      end
   end

   assign any = |req;

endmodule : rr_pick
`default_nettype wire

// File: rtl/axi_rd_master_arbiter.sv
`default_nettype none
// ============================================================================
// axi_rd_master_arbiter : round-robin owner of the shared AR/R path, AR -> RLAST
// Rev 1.0
// ============================================================================
module axi_rd_master_arbiter #(
   parameter int NUM_M       = 4,
   parameter int WDOG_CYCLES = 0,
   parameter int TCO         = 1
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic [3:0] m_ARVALID,
   input  logic [3:0] m_RREADY,
   input  logic       s_ARREADY,
   input  logic       s_RVALID,
   input  logic       s_RLAST,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_vld,
   output logic       rd_busy,
   output logic       wdog_err
);
   import axi_ic_pkg::*;

   // Fixed four-master datapath; TCO is a simulation delay with no RTL effect
   if (NUM_M != 4 || TCO < 0) begin : g_cfg_unsupported
   end

   rd_arb_state_e state_q, state_d;
   m_idx_t        last_q, last_d;
   logic [3:0]    grant_q, grant_d;
   m_idx_t        idx_q, idx_d;
   logic          vld_q, vld_d;
   logic          busy_q, busy_d;
   logic          werr_q, werr_d;

   logic [3:0]    w_pick_oh;
   m_idx_t        w_pick_idx;
   logic          w_pick_any;
   logic          w_ar_hs;
   logic          w_beat_hs;
   logic          w_last_hs;
   logic          w_wdog_fire;

   rr_pick u_rr_pick (
      .req     (m_ARVALID),
      .last    (last_q),
      .gnt_oh  (w_pick_oh),
      .gnt_idx (w_pick_idx),
      .any     (w_pick_any)
   );

   assign w_ar_hs   = m_ARVALID[idx_q] && s_ARREADY;
   assign w_beat_hs = s_RVALID && m_RREADY[idx_q];
   assign w_last_hs = w_beat_hs && s_RLAST;

   if (WDOG_CYCLES > 0) begin : g_wdog
      localparam int             c_CNT_W = $clog2(WDOG_CYCLES + 1);
      localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(WDOG_CYCLES);
      localparam logic [c_CNT_W-1:0] c_FIRE  = c_CNT_W'(WDOG_CYCLES - 1);

      logic [c_CNT_W-1:0] cnt_q, cnt_d;

      // Cleared outside R (so it starts at 0 on entry) and on every beat
      always_comb begin
         cnt_d = '0;
         if (state_q == R && !w_beat_hs) begin
            cnt_d = (cnt_q == c_MAX) ? cnt_q : cnt_q + 1'b1;
         end
      end

      always_ff @(posedge ACLK or negedge ARESETn) begin
         if (!ARESETn) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      // Fires on the edge where the idle count reaches the limit
      assign w_wdog_fire = (state_q == R) && !w_beat_hs && (cnt_q == c_FIRE);
   end else begin : g_no_wdog
      assign w_wdog_fire = 1'b0;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         grant_q <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         werr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         werr_q  <= werr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (w_pick_any)                state_d = AR;
         AR:      if (w_ar_hs)                   state_d = R;
         R:       if (w_last_hs || w_wdog_fire)  state_d = IDLE;
         default:                                state_d = IDLE;
      endcase
   end

   always_comb begin
      last_d  = last_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      werr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_d = w_pick_any ? w_pick_oh  : 4'b0000;
            idx_d   = w_pick_any ? w_pick_idx : 2'd0;
            vld_d   = w_pick_any;
            busy_d  = 1'b0;
         end
         AR: begin
            if (w_ar_hs) begin
               busy_d = 1'b1;
            end
         end
         R: begin
            if (w_last_hs || w_wdog_fire) begin
               last_d  = idx_q;
               grant_d = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
               busy_d  = 1'b0;
               werr_d  = w_wdog_fire;
            end
         end
         default: begin
            grant_d = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign grant     = grant_q;
   assign grant_idx = idx_q;
   assign grant_vld = vld_q;
   assign rd_busy   = busy_q;
   assign wdog_err  = werr_q;

endmodule : axi_rd_master_arbiter
`default_nettype wire
